icache: RTL and testbench



---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_array.sv | 54 +++++
 rtl/icache.sv | 126 ++++++++++++
 tb/tb_icache.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Packages  : rv32i_types, icache_types
//  Purpose   : Shared RV32I word type plus icache geometry constants and the
//              cache controller state encoding.
//  Revision  : 1.0 - initial release
// ============================================================================
package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage : rv32i_types

package icache_types;
    localparam int S_INDEX    = 4;
    localparam int S_OFFSET   = 5;
    localparam int S_TAG      = 32 - S_INDEX - S_OFFSET;
    localparam int LINE_WIDTH = 256;

    // Controller states: serving fetches, or waiting on a line fill
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_e;
endpackage : icache_types
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
//  Module    : icache_array
//  Purpose   : Per-set storage with asynchronous read and a single synchronous
//              write port; optionally cleared to zero by a synchronous clear.
//  Revision  : 1.0 - initial release
// ============================================================================
module icache_array #(
    parameter int WIDTH     = 1,
    parameter int S_INDEX   = 4,
    parameter bit HAS_CLEAR = 1'b0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               we,
    input  logic [S_INDEX-1:0] windex,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [S_INDEX-1:0] rindex,
    output logic [WIDTH-1:0]   rdata
);

    localparam int c_DEPTH = 2 ** S_INDEX;

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    generate
        if (HAS_CLEAR) begin : g_clear
            // Clear wins over a write issued in the same cycle
            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int i = 0; i < c_DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                end else if (we) begin
                    r_mem[windex] <= wdata;
                end
            end
        end else begin : g_noclear
            logic w_unused_clr;
            assign w_unused_clr = clr;

            // Plain write port; contents survive reset
            always_ff @(posedge clk) begin
                if (we) begin
                    r_mem[windex] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = r_mem[rindex];

endmodule : icache_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module    : icache
//  Purpose   : Direct-mapped, read-only L1 instruction cache. Hits answer in
//              the request cycle; misses refill a whole line from memory.
//  Revision  : 1.0 - initial release
// ============================================================================
module icache
    import rv32i_types::*;
#(
    parameter int S_INDEX  = icache_types::S_INDEX,
    parameter int S_OFFSET = icache_types::S_OFFSET
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mem_read,
    input  rv32i_word                       mem_address,
    output logic                            mem_resp,
    output rv32i_word                       mem_rdata,
    output logic                            pmem_read,
    output rv32i_word                       pmem_address,
    input  logic [8*(2**S_OFFSET)-1:0]      pmem_rdata,
    input  logic                            pmem_resp
);

    import icache_types::*;

    localparam int c_TAG_W  = 32 - S_INDEX - S_OFFSET;
    localparam int c_LINE_W = 8 * (2 ** S_OFFSET);
    localparam int c_WORD_W = S_OFFSET - 2;

    icache_state_e r_state;
    logic          r_pmem_read;
    rv32i_word     r_pmem_address;

    logic [c_TAG_W-1:0]  w_tag;
    logic [S_INDEX-1:0]  w_index;
    logic [c_WORD_W-1:0] w_word;
    logic [c_TAG_W-1:0]  w_fill_tag;
    logic [S_INDEX-1:0]  w_fill_index;
    logic                w_fill_we;
    logic                w_valid;
    logic [c_TAG_W-1:0]  w_stored_tag;
    logic [c_LINE_W-1:0] w_line;
    logic                w_hit;
    logic                w_unused;

    assign w_tag    = mem_address[31 -: c_TAG_W];
    assign w_index  = mem_address[S_OFFSET +: S_INDEX];
    assign w_word   = mem_address[2 +: c_WORD_W];
    assign w_unused = ^mem_address[1:0];

    // The outstanding fill address doubles as the latched tag/index, so a CPU
    // address change during the fill cannot redirect where the line lands.
    assign w_fill_tag   = r_pmem_address[31 -: c_TAG_W];
    assign w_fill_index = r_pmem_address[S_OFFSET +: S_INDEX];
    assign w_fill_we    = (r_state == FETCH) && pmem_resp && !rst;

    icache_array #(.WIDTH(c_LINE_W), .S_INDEX(S_INDEX), .HAS_CLEAR(1'b0)) u_data (
        .clk    (clk),
        .clr    (1'b0),
        .we     (w_fill_we),
        .windex (w_fill_index),
        .wdata  (pmem_rdata),
        .rindex (w_index),
        .rdata  (w_line)
    );

    icache_array #(.WIDTH(c_TAG_W), .S_INDEX(S_INDEX), .HAS_CLEAR(1'b0)) u_tag (
        .clk    (clk),
        .clr    (1'b0),
        .we     (w_fill_we),
        .windex (w_fill_index),
        .wdata  (w_fill_tag),
        .rindex (w_index),
        .rdata  (w_stored_tag)
    );

    icache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .HAS_CLEAR(1'b1)) u_valid (
        .clk    (clk),
        .clr    (rst),
        .we     (w_fill_we),
        .windex (w_fill_index),
        .wdata  (1'b1),
        .rindex (w_index),
        .rdata  (w_valid)
    );

    assign w_hit     = w_valid && (w_stored_tag == w_tag);
    assign mem_resp  = (r_state == IDLE) && mem_read && w_hit;
    assign mem_rdata = w_line[{w_word, 5'b00000} +: 32];

    assign pmem_read    = r_pmem_read;
    assign pmem_address = r_pmem_address;

    // Miss handling: latch the line address, request it, release on response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pmem_read    <= 1'b0;
            r_pmem_address <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_read && !w_hit) begin
                        r_state        <= FETCH;
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= {w_tag, w_index, {S_OFFSET{1'b0}}};
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        r_state     <= IDLE;
                        r_pmem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_pmem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module    : tb_icache
//  Purpose   : Self-checking bench for icache: directed vector table, hand
//              sequences for fill/reset corner cases, and random fetches
//              against a set-occupancy reference model.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic [31:0]  mem_address;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which 32-byte line each set holds
    bit          m_valid [16];
    logic [26:0] m_line  [16];

    icache u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory contents: an arbitrary function of the byte address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [255:0] make_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(la + 32'(4 * k));
        return l;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[8:5]] && (m_line[a[8:5]] == a[31:5]);
    endfunction

    task automatic model_install(input logic [31:0] la);
        m_valid[la[8:5]] = 1'b1;
        m_line[la[8:5]]  = la[31:5];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory side: answers after lat extra cycles, checking the request each cycle
    task automatic serve_fill(input logic [31:0] la, input int lat);
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            pmem_resp  = (k == lat);
            pmem_rdata = make_line(la);
            @(negedge clk);
            chk("fetch_pmem_read", {31'b0, pmem_read}, 32'd1);
            chk("fetch_pmem_addr", pmem_address, la);
            chk("fetch_no_resp", {31'b0, mem_resp}, 32'd0);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        model_install(la);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int lat, input bit exp_hit);
        @(posedge clk); #1;
        mem_read    = 1'b1;
        mem_address = addr;
        @(negedge clk);
        chk("req_resp", {31'b0, mem_resp}, {31'b0, exp_hit});
        chk("req_pmem_idle", {31'b0, pmem_read}, 32'd0);
        if (exp_hit) begin
            chk("hit_rdata", mem_rdata, mem_word(addr));
        end else begin
            serve_fill({addr[31:5], 5'b0}, lat);
            @(negedge clk);
            chk("fill_pmem_drop", {31'b0, pmem_read}, 32'd0);
            chk("fill_resp", {31'b0, mem_resp}, 32'd1);
            chk("fill_rdata", mem_rdata, mem_word(addr));
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
        bit          exp_hit;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{32'h0000_0000, 1,  1'b0};
        vecs[1] = '{32'h0000_001C, 0,  1'b1};
        vecs[2] = '{32'h0000_0200, 2,  1'b0};
        vecs[3] = '{32'h0000_0000, 0,  1'b0};
        vecs[4] = '{32'h0000_0040, 10, 1'b0};
        vecs[5] = '{32'h0000_0044, 0,  1'b1};
        vecs[6] = '{32'h0000_005C, 0,  1'b1};
        vecs[7] = '{32'h0000_0004, 0,  1'b1};

        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_address = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
        chk("rst_pmem_addr", pmem_address, 32'd0);
        chk("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            chk("table_model", {31'b0, model_hit(vecs[i].addr)}, {31'b0, vecs[i].exp_hit});
            do_fetch(vecs[i].addr, vecs[i].lat, vecs[i].exp_hit);
        end

        // Address changes mid-fill: fill still lands at 0x80, 0x100 misses after
        @(posedge clk); #1;
        mem_read    = 1'b1;
        mem_address = 32'h0000_0080;
        @(negedge clk);
        chk("chg_miss", {31'b0, mem_resp}, 32'd0);
        @(posedge clk); #1;
        mem_address = 32'h0000_0100;
        @(negedge clk);
        chk("chg_pmem_read", {31'b0, pmem_read}, 32'd1);
        chk("chg_pmem_addr", pmem_address, 32'h0000_0080);
        serve_fill(32'h0000_0080, 2);
        @(negedge clk);
        chk("chg_no_resp", {31'b0, mem_resp}, 32'd0);
        chk("chg_pmem_idle", {31'b0, pmem_read}, 32'd0);
        serve_fill(32'h0000_0100, 1);
        @(negedge clk);
        chk("chg2_resp", {31'b0, mem_resp}, 32'd1);
        chk("chg2_rdata", mem_rdata, mem_word(32'h0000_0100));
        do_fetch(32'h0000_0088, 0, 1'b1);

        // Reset in the third FETCH cycle abandons the fill
        @(posedge clk); #1;
        mem_address = 32'h0000_0300;
        @(negedge clk);
        chk("rstf_miss", {31'b0, mem_resp}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rstf_pmem_read", {31'b0, pmem_read}, 32'd1);
        end
        @(posedge clk); #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("rstf_pmem_hold", {31'b0, pmem_read}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rstf_pmem_drop", {31'b0, pmem_read}, 32'd0);
        chk("rstf_no_resp", {31'b0, mem_resp}, 32'd0);
        do_fetch(32'h0000_0300, 1, model_hit(32'h0000_0300));

        // Reset coincident with the fill response: nothing is installed
        @(posedge clk); #1;
        mem_address = 32'h0000_0400;
        @(negedge clk);
        chk("rstr_miss", {31'b0, mem_resp}, 32'd0);
        @(posedge clk); #1;
        rst        = 1'b1;
        mem_read   = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = make_line(32'h0000_0400);
        @(posedge clk); #1;
        rst       = 1'b0;
        pmem_resp = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rstr_pmem_drop", {31'b0, pmem_read}, 32'd0);
        do_fetch(32'h0000_0400, 0, model_hit(32'h0000_0400));
        do_fetch(32'h0000_0000, 0, model_hit(32'h0000_0000));

        // Random fetches over a few aliasing tags
        for (int r = 0; r < 150; r++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
                | (32'($urandom_range(0, 7)) << 2);
            do_fetch(a, int'($urandom_range(0, 3)), model_hit(a));
        end

        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_icache
`default_nettype wire
